mem_access: RTL and testbench

Memory-access stage of the mriscv pipeline, between execute and write-back. It takes one instruction at a time from execute and runs loads/stores on the native data bus (valid/ready, word-addressed, byte strobes). It aligns and sign/zero-extends load data. It presents `result`/`dest`/`next_pc` to write-back as a single-cycle `out_valid` pulse. Misaligned accesses and bus timeouts are reported as traps and suppress the register write (`dest` forced to 0).

---
 rtl/mriscv_pkg.sv | 16 +
 rtl/mem_align.sv | 53 +++++
 rtl/mem_access.sv | 133 +++++++++++++
 tb/tb_mem_access.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mriscv_pkg.sv
// Shared mriscv definitions: access-size encodings, memory-stage states and
// the default bus-timeout limit.
package mriscv_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int MAX_WAIT_DEFAULT = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper for the memory stage: store strobes, lane replication,
// misalignment detection and load extraction with sign/zero extension.
module mem_align
    import mriscv_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    // Move the field to the top of the word, then shift back down so the
    // arithmetic shift supplies the sign bits.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic uns);
        logic        [4:0]  sh;
        logic signed [31:0] s;
        sh = (sz == SZ_B) ? 5'd24 : (sz == SZ_H) ? 5'd16 : 5'd0;
        s  = signed'(v << sh);
        return uns ? (unsigned'(s) >> sh) : unsigned'(s >>> sh);
    endfunction

    always_comb begin
        st_strb    = 4'b0000;
        st_wdata   = st_data;
        misaligned = 1'b0;
        case (st_size)
            SZ_B: begin
                st_strb  = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_strb    = 4'b0011 << st_off;
                st_wdata   = {2{st_data[15:0]}};
                misaligned = st_off[0];
            end
            SZ_W: begin
                st_strb    = 4'b1111;
                misaligned = |st_off;
            end
            default: misaligned = 1'b1;
        endcase
        ld_data = extend(ld_rdata >> {ld_off, 3'b000}, ld_size, ld_unsigned);
    end

endmodule

// File: rtl/mem_access.sv
// mriscv memory-access stage: issues loads/stores on the valid/ready data bus
// and hands one result pulse per instruction to write-back.
module mem_access
    import mriscv_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_next_pc,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [4:0]  dest,
    output logic [31:0] next_pc,
    output logic        trap_misaligned,
    output logic        trap_bus_err
);

    localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [8:0]  wait_nxt;
    logic        op_load;
    logic        op_unsigned;
    logic [1:0]  op_off;
    logic [1:0]  op_size;
    logic [4:0]  op_dest;
    logic [31:0] op_pc;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic        misaligned;
    logic [31:0] ld_data;

    assign in_ready = (state == ST_IDLE);
    assign wait_nxt = {1'b0, wait_cnt} + 9'd1;

    mem_align u_align (
        .st_off      (alu_result[1:0]),
        .st_size     (size),
        .st_data     (rs2_data),
        .st_strb     (st_strb),
        .st_wdata    (st_wdata),
        .misaligned  (misaligned),
        .ld_off      (op_off),
        .ld_size     (op_size),
        .ld_unsigned (op_unsigned),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            op_load         <= 1'b0;
            op_unsigned     <= 1'b0;
            op_off          <= '0;
            op_size         <= '0;
            op_dest         <= '0;
            op_pc           <= '0;
            mem_valid       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wstrb       <= '0;
            out_valid       <= 1'b0;
            result          <= '0;
            dest            <= '0;
            next_pc         <= '0;
            trap_misaligned <= 1'b0;
            trap_bus_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: if (in_valid) begin
                    if (!(is_load || is_store) || misaligned) begin
                        out_valid       <= 1'b1;
                        result          <= misaligned && (is_load || is_store) ? '0 : alu_result;
                        dest            <= misaligned && (is_load || is_store) ? '0 : in_dest;
                        next_pc         <= in_next_pc;
                        trap_misaligned <= misaligned && (is_load || is_store);
                        trap_bus_err    <= 1'b0;
                    end else begin
                        mem_valid   <= 1'b1;
                        mem_addr    <= {alu_result[31:2], 2'b00};
                        mem_wdata   <= st_wdata;
                        mem_wstrb   <= is_load ? 4'b0000 : st_strb;
                        op_load     <= is_load;
                        op_unsigned <= is_unsigned;
                        op_off      <= alu_result[1:0];
                        op_size     <= size;
                        op_dest     <= in_dest;
                        op_pc       <= in_next_pc;
                        wait_cnt    <= '0;
                        state       <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // A ready on the limit cycle still completes normally.
                    if (mem_ready || wait_nxt == WAIT_LIMIT) begin
                        mem_valid       <= 1'b0;
                        out_valid       <= 1'b1;
                        result          <= (mem_ready && op_load) ? ld_data : '0;
                        dest            <= (mem_ready && op_load) ? op_dest : '0;
                        next_pc         <= op_pc;
                        trap_misaligned <= 1'b0;
                        trap_bus_err    <= !mem_ready;
                        state           <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_nxt[7:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops
// compared against a byte-arithmetic reference model.
module tb_mem_access;

    localparam int MAXW = 4;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  in_dest;
    logic [31:0] in_next_pc;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] result;
    logic [4:0]  dest;
    logic [31:0] next_pc;
    logic        trap_misaligned;
    logic        trap_bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access #(.MAX_WAIT(MAXW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .alu_result      (alu_result),
        .rs2_data        (rs2_data),
        .in_dest         (in_dest),
        .in_next_pc      (in_next_pc),
        .is_load         (is_load),
        .is_store        (is_store),
        .size            (size),
        .is_unsigned     (is_unsigned),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_rdata       (mem_rdata),
        .out_valid       (out_valid),
        .result          (result),
        .dest            (dest),
        .next_pc         (next_pc),
        .trap_misaligned (trap_misaligned),
        .trap_bus_err    (trap_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction end to end. rc is the bus cycle (1-based) carrying
    // mem_ready; rc > MAXW means the bus never answers.
    task automatic do_op(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] dst, input logic [31:0] pc, input int rc,
                         input logic [31:0] rdata);
        int          off, nb, hi, strb_i;
        logic        mem, mis, berr, done;
        logic [31:0] ew, eres;
        logic [4:0]  edst;
        longint      v;

        off  = int'(addr[1:0]);
        nb   = 1 << sz;
        mem  = ld | st;
        mis  = mem && (sz == 2'd3 || (off % nb) != 0);
        berr = mem && !mis && rc > MAXW;
        strb_i = ld ? 0 : (((1 << nb) - 1) << off) & 15;
        for (int i = 0; i < 4; i++) ew[8*i +: 8] = data[8*(i % nb) +: 8];
        v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
        if (!uns && ((v >> (8 * nb - 1)) & 1) != 0) v = v - (longint'(1) << (8 * nb));
        eres = !mem ? addr : (mis || berr || !ld) ? 32'h0 : v[31:0];
        edst = (!mem || (ld && !mis && !berr)) ? dst : 5'd0;

        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; is_load = ld; is_store = st; size = sz; is_unsigned = uns;
        alu_result = addr; rs2_data = data; in_dest = dst; in_next_pc = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!mem || mis) begin
            check("no_bus_cycle", 32'(mem_valid), 32'd0);
        end else begin
            check("out_valid_early", 32'(out_valid), 32'd0);
            hi = 0; done = 1'b0;
            for (int c = 1; c <= 10 && !done; c++) begin
                check("mem_valid_hi", 32'(mem_valid), 32'd1);
                check("in_ready_bus", 32'(in_ready), 32'd0);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_wstrb", 32'(mem_wstrb), 32'(strb_i));
                if (!ld) check("mem_wdata", mem_wdata, ew);
                hi++;
                mem_ready = (c == rc);
                mem_rdata = (c == rc) ? rdata : $urandom;
                @(posedge clk); #1;
                mem_ready = 1'b0;
                done = out_valid;
            end
            check("bus_cycles", 32'(hi), 32'((rc < MAXW) ? rc : MAXW));
            check("mem_valid_drop", 32'(mem_valid), 32'd0);
            check("in_ready_after", 32'(in_ready), 32'd1);
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("result", result, eres);
        check("dest", 32'(dest), 32'(edst));
        check("next_pc", next_pc, pc);
        check("trap_misaligned", 32'(trap_misaligned), 32'(mis));
        check("trap_bus_err", 32'(trap_bus_err), 32'(berr));
        @(posedge clk); #1;
        check("single_pulse", 32'(out_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; alu_result = '0; rs2_data = '0; in_dest = '0;
        in_next_pc = '0; is_load = 1'b0; is_store = 1'b0; size = '0; is_unsigned = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_dest", 32'(dest), 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("idle_ready_ignored", 32'(out_valid), 32'd0);

        do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 32'h0000_0040, 1, 32'h0);

        // back-to-back ALU ops
        in_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
        alu_result = 32'hAAAA_0001; in_dest = 5'd7; in_next_pc = 32'h100;
        @(posedge clk); #1;
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_result", result, 32'hAAAA_0001);
        check("b2b_first_dest", 32'(dest), 32'd7);
        alu_result = 32'hBBBB_0002; in_dest = 5'd9; in_next_pc = 32'h104;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_result", result, 32'hBBBB_0002);
        check("b2b_second_dest", 32'(dest), 32'd9);
        check("b2b_second_pc", next_pc, 32'h104);
        @(posedge clk); #1;
        check("b2b_pulse_end", 32'(out_valid), 32'd0);

        // directed memory cases
        do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 5'd3, 32'h200, 3, 32'h80AA_BBCC);
        do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 5'd3, 32'h204, 3, 32'h80AA_BBCC);
        check("lbu_value", result, 32'h0000_0080);
        do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 5'd4, 32'h208, 2, 32'h0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 5'd6, 32'h20C, 1, 32'h0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 5'd8, 32'h210, 5, 32'h0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 5'd8, 32'h214, 4, 32'hCAFE_F00D);
        do_op(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0400, 32'h1, 5'd2, 32'h218, 1, 32'h0);
        do_op(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0502, 32'h5555_5555, 5'd10, 32'h21C, 1, 32'h0000_8001);

        // randomized ops
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 7);
            do_op(k == 1 || k == 2 || k == 7, k == 3 || k == 4 || k == 7,
                  2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                  5'($urandom), $urandom, $urandom_range(1, 5), $urandom);
        end

        // reset during a bus cycle
        in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; size = 2'd2;
        alu_result = 32'h0000_0600; in_dest = 5'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_bus_started", 32'(mem_valid), 32'd1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("abort_no_stale_pulse", 32'(out_valid), 32'd0);
            check("abort_idle", 32'(in_ready), 32'd1);
        end
        do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0BAD_F00D, 32'h0, 5'd1, 32'h300, 1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
